// File: rtl/keypad_entry.sv
// Keypad front end: synchronises and debounces 12 raw key lines, emits one ASCII
// character per press to the LCD controller, and keeps a BCD digit-entry buffer.
module keypad_entry #(
    parameter int DB_CNT = 1000000,
    parameter int CNT_W  = 20,
    parameter int DEPTH  = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [11:0]        Keypad,
    input  logic               LCD_RDY,
    output logic               CHK,
    output logic [7:0]         LCD_DATA_in,
    output logic [4*DEPTH-1:0] ENTRY_BCD,
    output logic [4:0]         ENTRY_LEN,
    output logic               ENTRY_VALID
);

    typedef enum logic [1:0] {
        IDLE,
        EVENT,
        WAIT_REL
    } state_t;

    localparam int               IDX_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);
    localparam logic [4:0]       FULL    = 5'(DEPTH);

    logic [11:0]             sync1;
    logic [11:0]             sync2;
    logic [11:0]             prev;
    logic [CNT_W-1:0]        db_cnt;
    logic                    stable;

    state_t                  state;
    logic [11:0]             key_q;
    logic [3:0]              digit;
    logic [DEPTH-1:0][3:0]   work_buf;
    logic [4:0]              work_len;
    logic [IDX_W-1:0]        wr_idx;
    logic [IDX_W-1:0]        del_idx;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1  <= '0;
            sync2  <= '0;
            prev   <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= Keypad;
            sync2 <= sync1;
            prev  <= sync2;
            if (sync2 != prev) begin
                db_cnt <= '0;
            end else if (db_cnt != CNT_MAX) begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // A pattern that changes on the very cycle the count saturates is not yet stable.
    assign stable = (db_cnt == CNT_MAX) && (sync2 == prev);

    // NOTE: default assignment first so no path leaves digit unassigned (no latch).
    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_q[i]) begin
                digit = 4'(i);
            end
        end
    end

    assign wr_idx  = work_len[IDX_W-1:0];
    assign del_idx = wr_idx - 1'b1;

    // NOTE: the entry buffer is ordinary register state, so it is cleared on reset with everything else.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            key_q       <= '0;
            work_buf    <= '0;
            work_len    <= '0;
            CHK         <= 1'b0;
            LCD_DATA_in <= 8'h00;
            ENTRY_BCD   <= '0;
            ENTRY_LEN   <= '0;
            ENTRY_VALID <= 1'b0;
        end else begin
            ENTRY_VALID <= 1'b0;
            if (CHK && LCD_RDY) begin
                CHK <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // A single key waits here while a character is still pending.
                    if (stable && sync2 != '0) begin
                        if (!$onehot(sync2)) begin
                            state <= WAIT_REL;
                        end else if (!CHK) begin
                            key_q <= sync2;
                            state <= EVENT;
                        end
                    end
                end

                EVENT: begin
                    state <= WAIT_REL;
                    if (key_q[11]) begin
                        ENTRY_BCD   <= work_buf;
                        ENTRY_LEN   <= work_len;
                        ENTRY_VALID <= 1'b1;
                        work_buf    <= '0;
                        work_len    <= '0;
                        CHK         <= 1'b1;
                        LCD_DATA_in <= 8'h0D;
                    end else if (key_q[10]) begin
                        if (work_len != 5'd0) begin
                            work_buf[del_idx] <= 4'd0;
                            work_len          <= work_len - 5'd1;
                            CHK               <= 1'b1;
                            LCD_DATA_in       <= 8'h08;
                        end
                    end else if (work_len != FULL) begin
                        work_buf[wr_idx] <= digit;
                        work_len         <= work_len + 5'd1;
                        CHK              <= 1'b1;
                        LCD_DATA_in      <= {4'h3, digit};
                    end
                end

                WAIT_REL: begin
                    if (stable && sync2 == '0) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed corner sequences, a table of key presses with
// expected characters/commits, and random presses scored against a digit-list model.
module tb_keypad_entry;

    localparam int DB = 4;

    logic        clk;
    logic        rst;
    logic [11:0] keypad;
    logic        lcd_rdy;
    logic        chk;
    logic [7:0]  lcd_data;
    logic [63:0] entry_bcd;
    logic [4:0]  entry_len;
    logic        entry_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  got_chars [$];
    int          got_len   [$];
    logic [63:0] got_bcd   [$];
    int          valid_cnt = 0;

    bit rdy_rand = 0;
    int zero_run = 0;

    typedef struct {
        string       name;
        logic [11:0] key;
        bit          has_char;
        logic [7:0]  ch;
        bit          commit;
        int          len;
        logic [63:0] bcd;
    } vec_t;

    keypad_entry #(
        .DB_CNT(DB),
        .CNT_W (20),
        .DEPTH (16)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .Keypad     (keypad),
        .LCD_RDY    (lcd_rdy),
        .CHK        (chk),
        .LCD_DATA_in(lcd_data),
        .ENTRY_BCD  (entry_bcd),
        .ENTRY_LEN  (entry_len),
        .ENTRY_VALID(entry_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    // Record every accepted character and every commit pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (chk && lcd_rdy) got_chars.push_back(lcd_data);
            if (entry_valid) begin
                valid_cnt++;
                got_len.push_back(int'(entry_len));
                got_bcd.push_back(entry_bcd);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rdy_rand) begin
                if (zero_run >= 3 || $urandom_range(0, 1) == 1) begin
                    lcd_rdy  = 1'b1;
                    zero_run = 0;
                end else begin
                    lcd_rdy = 1'b0;
                    zero_run++;
                end
            end
        end
    endtask

    task automatic press(input logic [11:0] key, input int hold, input int gap);
        keypad = key;
        tick(hold);
        keypad = '0;
        tick(gap);
    endtask

    initial begin
        vec_t        vecs [11];
        int          k;
        int          c0;
        int          v0;
        int          bad;
        int          mdl [$];
        logic [7:0]  exp_ch [$];
        int          exp_len [$];
        logic [63:0] exp_bcd [$];
        logic [63:0] pack;
        logic [11:0] key;
        int          sel;
        int          d;
        int          b1;
        int          b2;

        vecs = '{
            '{"hash_35",         12'h800, 1'b1, 8'h0D, 1'b1, 2, 64'h53},
            '{"digit1",          12'h002, 1'b1, 8'h31, 1'b0, 0, 64'h0},
            '{"digit2",          12'h004, 1'b1, 8'h32, 1'b0, 0, 64'h0},
            '{"digit3",          12'h008, 1'b1, 8'h33, 1'b0, 0, 64'h0},
            '{"star_del",        12'h400, 1'b1, 8'h08, 1'b0, 0, 64'h0},
            '{"digit4",          12'h010, 1'b1, 8'h34, 1'b0, 0, 64'h0},
            '{"hash_421",        12'h800, 1'b1, 8'h0D, 1'b1, 3, 64'h421},
            '{"star_empty",      12'h400, 1'b0, 8'h00, 1'b0, 0, 64'h0},
            '{"multi_03",        12'h003, 1'b0, 8'h00, 1'b0, 0, 64'h0},
            '{"multi_star_hash", 12'hC00, 1'b0, 8'h00, 1'b0, 0, 64'h0},
            '{"hash_empty",      12'h800, 1'b1, 8'h0D, 1'b1, 0, 64'h0}
        };

        rst     = 1'b1;
        keypad  = '0;
        lcd_rdy = 1'b1;
        tick(3);
        check("reset_chk", chk, 1'b0);
        check("reset_data", lcd_data, 8'h00);
        check("reset_bcd", entry_bcd, 64'h0);
        check("reset_len", entry_len, 5'd0);
        check("reset_valid", entry_valid, 1'b0);
        rst = 1'b0;
        tick(10);

        // Single press: latency from first sampling edge, one character, none on release.
        c0     = got_chars.size();
        keypad = 12'h008;
        k      = 0;
        while (!chk && k < 30) begin
            tick(1);
            k++;
        end
        check("press_latency", k, DB + 4);
        tick(20 - k);
        keypad = '0;
        tick(20);
        check("press_count", got_chars.size() - c0, 1);
        if (got_chars.size() > c0) check("press_char", got_chars[c0], 8'h33);

        // Bounce on key 5 shorter than the debounce window, then a clean hold.
        c0 = got_chars.size();
        for (int i = 0; i < 6; i++) begin
            keypad = (i % 2 == 0) ? 12'h020 : 12'h000;
            tick(2);
        end
        check("bounce_quiet", got_chars.size() - c0, 0);
        keypad = 12'h020;
        tick(20);
        keypad = '0;
        tick(20);
        check("bounce_count", got_chars.size() - c0, 1);
        if (got_chars.size() > c0) check("bounce_char", got_chars[c0], 8'h35);

        for (int i = 0; i < 11; i++) begin
            c0 = got_chars.size();
            v0 = valid_cnt;
            press(vecs[i].key, 20, 20);
            check({vecs[i].name, "_nchar"}, got_chars.size() - c0, vecs[i].has_char);
            if (vecs[i].has_char && got_chars.size() > c0)
                check({vecs[i].name, "_char"}, got_chars[c0], vecs[i].ch);
            check({vecs[i].name, "_pulses"}, valid_cnt - v0, vecs[i].commit);
            if (vecs[i].commit) begin
                check({vecs[i].name, "_len"}, entry_len, vecs[i].len);
                check({vecs[i].name, "_bcd"}, entry_bcd, vecs[i].bcd);
            end
        end

        // Seventeen sevens: the buffer holds sixteen, the last press is silent.
        c0 = got_chars.size();
        for (int i = 0; i < 17; i++) press(12'h080, 20, 20);
        check("full_count", got_chars.size() - c0, 16);
        bad = 0;
        for (int i = c0; i < got_chars.size(); i++) if (got_chars[i] != 8'h37) bad++;
        check("full_chars", bad, 0);
        check("full_len_before_commit", entry_len, 5'd0);
        press(12'h800, 20, 20);
        check("full_len", entry_len, 5'd16);
        check("full_bcd", entry_bcd, 64'h7777_7777_7777_7777);

        // Back-pressure: '9' stays on the bus while '0' is pressed and held.
        c0      = got_chars.size();
        lcd_rdy = 1'b0;
        press(12'h200, 20, 20);
        check("hold9_chk", chk, 1'b1);
        check("hold9_data", lcd_data, 8'h39);
        keypad = 12'h001;
        tick(20);
        check("hold0_chk", chk, 1'b1);
        check("hold0_data", lcd_data, 8'h39);
        check("hold0_none", got_chars.size() - c0, 0);
        lcd_rdy = 1'b1;
        tick(20);
        keypad = '0;
        tick(20);
        check("bp_count", got_chars.size() - c0, 2);
        if (got_chars.size() > c0 + 1) begin
            check("bp_first", got_chars[c0], 8'h39);
            check("bp_second", got_chars[c0 + 1], 8'h30);
        end

        // Reset while a character is pending drops it and clears all entry state.
        lcd_rdy = 1'b0;
        keypad  = 12'h020;
        tick(20);
        check("prereset_chk", chk, 1'b1);
        rst = 1'b1;
        tick(1);
        check("midreset_chk", chk, 1'b0);
        check("midreset_len", entry_len, 5'd0);
        check("midreset_data", lcd_data, 8'h00);
        check("midreset_bcd", entry_bcd, 64'h0);
        keypad = '0;
        tick(2);
        rst     = 1'b0;
        lcd_rdy = 1'b1;
        tick(20);
        c0 = got_chars.size();
        press(12'h800, 20, 20);
        check("postreset_len", entry_len, 5'd0);
        check("postreset_bcd", entry_bcd, 64'h0);
        check("postreset_nchar", got_chars.size() - c0, 1);

        // Random presses against a digit-list model with random LCD back-pressure.
        c0       = got_chars.size();
        v0       = got_len.size();
        rdy_rand = 1;
        zero_run = 0;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                d   = $urandom_range(0, 9);
                key = 12'b1 << d;
                if (mdl.size() < 16) begin
                    mdl.push_back(d);
                    exp_ch.push_back(8'h30 + 8'(d));
                end
            end else if (sel == 6) begin
                key = 12'h400;
                if (mdl.size() > 0) begin
                    void'(mdl.pop_back());
                    exp_ch.push_back(8'h08);
                end
            end else if (sel == 7) begin
                key  = 12'h800;
                pack = '0;
                for (int i = 0; i < mdl.size(); i++) pack[4*i +: 4] = 4'(mdl[i]);
                exp_len.push_back(mdl.size());
                exp_bcd.push_back(pack);
                exp_ch.push_back(8'h0D);
                mdl.delete();
            end else begin
                b1  = $urandom_range(0, 11);
                b2  = (b1 + $urandom_range(1, 11)) % 12;
                key = (12'b1 << b1) | (12'b1 << b2);
            end
            press(key, 20, 20);
        end
        rdy_rand = 0;
        lcd_rdy  = 1'b1;
        tick(10);
        check("rand_nchars", got_chars.size() - c0, exp_ch.size());
        bad = 0;
        for (int i = 0; i < exp_ch.size() && c0 + i < got_chars.size(); i++)
            if (got_chars[c0 + i] != exp_ch[i]) bad++;
        check("rand_char_mismatches", bad, 0);
        check("rand_ncommits", got_len.size() - v0, exp_len.size());
        bad = 0;
        for (int i = 0; i < exp_len.size() && v0 + i < got_len.size(); i++)
            if (got_len[v0 + i] != exp_len[i] || got_bcd[v0 + i] != exp_bcd[i]) bad++;
        check("rand_commit_mismatches", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
